// File: rtl/intr_gateway_arb_if.sv
// intr_gateway_arb_if: request, claim/complete and status signals of the interrupt gateway.
interface intr_gateway_arb_if #(
  parameter int NumSrc  = 28,
  parameter int IdWidth = $clog2(NumSrc + 1)
);
  logic [NumSrc-1:0]  intr_src_i;
  logic [NumSrc-1:0]  intr_en_i;
  logic               claim_i;
  logic               complete_i;
  logic [IdWidth-1:0] complete_id_i;
  logic               irq_o;
  logic [IdWidth-1:0] claim_id_o;
  logic [NumSrc-1:0]  pending_o;
  logic [NumSrc-1:0]  in_service_o;
  modport master (
    output intr_src_i, intr_en_i, claim_i, complete_i, complete_id_i,
    input  irq_o, claim_id_o, pending_o, in_service_o
  );
  modport slave (
    input  intr_src_i, intr_en_i, claim_i, complete_i, complete_id_i,
    output irq_o, claim_id_o, pending_o, in_service_o
  );
endinterface

// File: rtl/intr_gateway_arb.sv
// intr_gateway_arb: per-source level gateways and fixed-priority claim/complete arbiter.
module intr_gateway_arb #(
  parameter int NumSrc  = 28,
  parameter int IdWidth = $clog2(NumSrc + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  intr_gateway_arb_if.slave   bus
);
  logic [NumSrc-1:0]  pending_q, pending_d, in_service_q, in_service_d;
  logic [NumSrc-1:0]  elig, claim_oh, cmp_oh;
  logic [IdWidth-1:0] claim_id_q, claim_id_d, win_id;
  logic               irq_q, irq_d, cmp_ok;
  always_comb begin
    elig = pending_q & bus.intr_en_i;
    win_id = '0;
    for (int k = NumSrc - 1; k >= 0; k--) if (elig[k]) win_id = IdWidth'(k + 1);
    claim_oh = (bus.claim_i && win_id != '0) ? (NumSrc'(1) << (win_id - 1'b1)) : '0;
    cmp_ok = bus.complete_i && bus.complete_id_i != '0 && bus.complete_id_i <= IdWidth'(NumSrc);
    cmp_oh = cmp_ok ? ((NumSrc'(1) << (bus.complete_id_i - 1'b1)) & in_service_q) : '0;
    // gateway re-arms only once both pending and in-service are clear pre-edge
    pending_d = (pending_q | (bus.intr_src_i & ~pending_q & ~in_service_q)) & ~claim_oh;
    in_service_d = (in_service_q & ~cmp_oh) | claim_oh;
    claim_id_d = bus.claim_i ? win_id : claim_id_q;
    // newly latched sources reach irq one edge later; a claim drops its source at once
    irq_d = |(pending_q & ~claim_oh & bus.intr_en_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q    <= '0;
      in_service_q <= '0;
      claim_id_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      claim_id_q   <= claim_id_d;
      irq_q        <= irq_d;
    end
  end
  assign bus.irq_o        = irq_q;
  assign bus.claim_id_o   = claim_id_q;
  assign bus.pending_o    = pending_q;
  assign bus.in_service_o = in_service_q;
endmodule

// File: tb/tb_intr_gateway_arb.sv
// tb_intr_gateway_arb: table-driven directed checks of the interrupt gateway/arbiter.
module tb_intr_gateway_arb;
  localparam logic [27:0] E = 28'hFFFFFFF;
  localparam logic [27:0] M = 28'hFFFFDFF;
  typedef struct {
    logic [27:0] src, en;
    logic        claim, cmp;
    logic [4:0]  cid_in;
    logic        irq;
    logic [4:0]  cid;
    logic [27:0] pend, isv;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int tests = 0, fails = 0;
  vec_t v[$];
  intr_gateway_arb_if #(.NumSrc(28)) bus ();
  intr_gateway_arb #(.NumSrc(28)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic irq, input logic [4:0] cid,
                         input logic [27:0] pend, input logic [27:0] isv);
    chk({nm, " irq"}, 32'(bus.irq_o), 32'(irq));
    chk({nm, " claim_id"}, 32'(bus.claim_id_o), 32'(cid));
    chk({nm, " pending"}, 32'(bus.pending_o), 32'(pend));
    chk({nm, " in_service"}, 32'(bus.in_service_o), 32'(isv));
  endtask
  task automatic step(input logic [27:0] src, input logic [27:0] en, input logic claim,
                      input logic cmp, input logic [4:0] cid);
    bus.intr_src_i = src;
    bus.intr_en_i = en;
    bus.claim_i = claim;
    bus.complete_i = cmp;
    bus.complete_id_i = cid;
    @(posedge clk);
    #1;
  endtask
  function automatic void add(input logic [27:0] src, input logic [27:0] en, input logic claim,
                              input logic cmp, input logic [4:0] cid_in, input logic irq,
                              input logic [4:0] cid, input logic [27:0] pend, input logic [27:0] isv);
    vec_t t;
    t.src = src; t.en = en; t.claim = claim; t.cmp = cmp; t.cid_in = cid_in;
    t.irq = irq; t.cid = cid; t.pend = pend; t.isv = isv;
    v.push_back(t);
  endfunction
  initial begin
    //  src        en claim cmp id    irq cid   pend       isv
    add(28'h8,     E, 0, 0, 5'd0,  0, 5'd0, 28'h8,   28'h0);
    add(28'h8,     E, 0, 0, 5'd0,  1, 5'd0, 28'h8,   28'h0);
    add(28'h8,     E, 1, 0, 5'd0,  0, 5'd4, 28'h0,   28'h8);
    add(28'h8,     E, 0, 0, 5'd0,  0, 5'd4, 28'h0,   28'h8);
    add(28'h8,     E, 0, 1, 5'd4,  0, 5'd4, 28'h0,   28'h0);
    add(28'h8,     E, 0, 0, 5'd0,  0, 5'd4, 28'h8,   28'h0);
    add(28'h8,     E, 0, 0, 5'd0,  1, 5'd4, 28'h8,   28'h0);
    add(28'h0,     E, 1, 0, 5'd0,  0, 5'd4, 28'h0,   28'h8);
    add(28'h0,     E, 0, 1, 5'd4,  0, 5'd4, 28'h0,   28'h0);
    add(28'h0,     E, 0, 0, 5'd0,  0, 5'd4, 28'h0,   28'h0);
    add(28'h12,    E, 0, 0, 5'd0,  0, 5'd4, 28'h12,  28'h0);
    add(28'h0,     E, 1, 0, 5'd0,  1, 5'd2, 28'h10,  28'h2);
    add(28'h0,     E, 1, 0, 5'd0,  0, 5'd5, 28'h0,   28'h12);
    add(28'h0,     E, 1, 0, 5'd0,  0, 5'd0, 28'h0,   28'h12);
    add(28'h0,     E, 0, 1, 5'd2,  0, 5'd0, 28'h0,   28'h10);
    add(28'h0,     E, 0, 1, 5'd5,  0, 5'd0, 28'h0,   28'h0);
    add(28'h8,     E, 0, 0, 5'd0,  0, 5'd0, 28'h8,   28'h0);
    add(28'h0,     E, 1, 0, 5'd0,  0, 5'd4, 28'h0,   28'h8);
    add(28'h0,     E, 0, 1, 5'd0,  0, 5'd4, 28'h0,   28'h8);
    add(28'h0,     E, 0, 1, 5'd29, 0, 5'd4, 28'h0,   28'h8);
    add(28'h0,     E, 0, 1, 5'd31, 0, 5'd4, 28'h0,   28'h8);
    add(28'h0,     E, 0, 1, 5'd7,  0, 5'd4, 28'h0,   28'h8);
    add(28'h40,    E, 1, 1, 5'd7,  0, 5'd0, 28'h40,  28'h8);
    add(28'h0,     E, 1, 1, 5'd7,  0, 5'd7, 28'h0,   28'h48);
    add(28'h0,     E, 0, 1, 5'd7,  0, 5'd7, 28'h0,   28'h8);
    add(28'h0,     E, 0, 1, 5'd4,  0, 5'd7, 28'h0,   28'h0);
    add(28'h200,   M, 0, 0, 5'd0,  0, 5'd7, 28'h200, 28'h0);
    add(28'h200,   M, 0, 0, 5'd0,  0, 5'd7, 28'h200, 28'h0);
    add(28'h200,   M, 1, 0, 5'd0,  0, 5'd0, 28'h200, 28'h0);
    add(28'h200,   E, 0, 0, 5'd0,  1, 5'd0, 28'h200, 28'h0);
    add(28'h0,     E, 1, 0, 5'd0,  0, 5'd10, 28'h0,  28'h200);
    add(28'h0,     E, 0, 1, 5'd10, 0, 5'd10, 28'h0,  28'h0);
    bus.intr_src_i = '0;
    bus.intr_en_i = '0;
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b0;
    bus.complete_id_i = '0;
    #1;
    chk_all("reset", 1'b0, 5'd0, 28'h0, 28'h0);
    #11 rst_n = 1'b1;
    foreach (v[i]) begin
      step(v[i].src, v[i].en, v[i].claim, v[i].cmp, v[i].cid_in);
      chk_all($sformatf("v%0d", i), v[i].irq, v[i].cid, v[i].pend, v[i].isv);
    end
    // async reset with two sources pending and one in service
    step(28'h3, E, 0, 0, 5'd0);
    step(28'h3, E, 1, 0, 5'd0);
    chk_all("pre_rst_claim", 1'b1, 5'd1, 28'h2, 28'h1);
    step(28'h7, E, 0, 0, 5'd0);
    chk_all("pre_rst", 1'b1, 5'd1, 28'h6, 28'h1);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 1'b0, 5'd0, 28'h0, 28'h0);
    #2 rst_n = 1'b1;
    step(28'h7, E, 0, 0, 5'd0);
    chk_all("post_rst1", 1'b0, 5'd0, 28'h7, 28'h0);
    step(28'h7, E, 0, 0, 5'd0);
    chk_all("post_rst2", 1'b1, 5'd0, 28'h7, 28'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
